mcu_cmd_sequencer: RTL

MCU_CMD_SEQUENCER -- requirements
Module: mcu_cmd_sequencer

---
 rtl/mcu_pkg.sv | 30 +++
 rtl/mcu_res_fifo.sv | 44 ++++
 rtl/mcu_cmd_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared opcode map, NOP command fields and FSM state encoding for the command sequencer.
package mcu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_READ  = 4'd7;
  localparam logic [3:0] OP_WRITE = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // A NOP looks like a read of address 0; only the cleared rd_flag tells them apart.
  localparam logic [3:0] NOP_OP      = OP_READ;
  localparam logic       NOP_RD_FLAG = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  function automatic logic is_read(input logic [3:0] op);
    return op == OP_READ;
  endfunction

endpackage

// File: rtl/mcu_res_fifo.sv
// Two-entry result FIFO; exposes its occupancy so the sequencer can throttle reads.
module mcu_res_fifo #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mcu_cmd_sequencer.sv
// Loads a program of target commands, replays it as registered mcu_* commands, throttles
// reads against a 2-entry result FIFO and stops on HALT, end of program or a target error.
module mcu_cmd_sequencer
  import mcu_pkg::*;
#(
  parameter int op_sz      = 32,
  parameter int mem_sz     = 4,
  parameter int PROG_DEPTH = 16,
  parameter int INSTR_W    = 4 + 2*mem_sz + op_sz
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_valid,
  output logic               prog_ready,
  input  logic [INSTR_W-1:0] prog_instr,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         mcu_op,
  output logic [mem_sz-1:0]  mcu_op0,
  output logic [op_sz-1:0]   mcu_op1,
  output logic [mem_sz-1:0]  mcu_op2,
  input  logic [op_sz-1:0]   mcu_out,
  input  logic               mcu_op_err,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [op_sz-1:0]   res_data
);

  // Handshakes: a word/result moves on a cycle where valid && ready are both high at the
  // rising edge; valid never depends combinationally on ready on either port.

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int CW = $clog2(PROG_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(PROG_DEPTH);

  state_e              state_q, state_d;
  logic [CW-1:0]       pc_q, pc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [3:0]          op_q, op_d;
  logic [mem_sz-1:0]   op0_q, op0_d;
  logic [op_sz-1:0]    op1_q, op1_d;
  logic [mem_sz-1:0]   op2_q, op2_d;
  logic                rd_q, rd_d;

  logic [INSTR_W-1:0]  prog_mem [PROG_DEPTH];
  logic [INSTR_W-1:0]  f_instr;
  logic [3:0]          f_op;
  logic [mem_sz-1:0]   f_op0;
  logic [op_sz-1:0]    f_op1;
  logic [mem_sz-1:0]   f_op2;

  logic                load_fire;
  logic                cmd_real;
  logic                end_issue;
  logic                rd_room;
  logic [1:0]          fifo_cnt;
  logic [1:0]          pending;

  // Program storage carries no reset; count_q alone decides which words are live.
  always_ff @(posedge clk) begin
    if (reset && load_fire) prog_mem[count_q[AW-1:0]] <= prog_instr;
  end

  assign f_instr = prog_mem[pc_q[AW-1:0]];
  assign f_op    = f_instr[INSTR_W-1 -: 4];
  assign f_op0   = f_instr[2*mem_sz+op_sz-1 -: mem_sz];
  assign f_op1   = f_instr[mem_sz+op_sz-1 -: op_sz];
  assign f_op2   = f_instr[mem_sz-1:0];

  assign load_fire = prog_valid && prog_ready;
  assign cmd_real  = (op_q != NOP_OP) || rd_q;
  assign end_issue = (pc_q == count_q) || (f_op == OP_HALT);
  // The registered read lands in the FIFO at the end of this cycle, so it counts as occupied.
  assign pending   = fifo_cnt + {1'b0, rd_q};
  assign rd_room   = (pending < 2'd2);

  mcu_res_fifo #(.W(op_sz)) u_res_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (rd_q),
    .push_data_i (mcu_out),
    .pop_i       (res_ready),
    .valid_o     (res_valid),
    .data_o      (res_data),
    .count_o     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      op_q    <= NOP_OP;
      op0_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= NOP_RD_FLAG;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      op_q    <= op_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    op_d    = NOP_OP;
    op0_d   = '0;
    op1_d   = '0;
    op2_d   = '0;
    rd_d    = NOP_RD_FLAG;
    unique case (state_q)
      ST_IDLE: begin
        if (load_fire) count_d = count_q + 1'b1;
        if (start) begin
          pc_d    = '0;
          state_d = ((count_q != '0) || load_fire) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // An error on the command now at the target wins over HALT and over any new issue.
        if (mcu_op_err && cmd_real) begin
          state_d = ST_ERR;
        end else if (end_issue) begin
          state_d = ST_DONE;
        end else if (!is_read(f_op) || rd_room) begin
          op_d  = f_op;
          op0_d = f_op0;
          op1_d = f_op1;
          op2_d = f_op2;
          rd_d  = is_read(f_op);
          pc_d  = pc_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    err        = (state_q == ST_ERR);
    prog_ready = (state_q == ST_IDLE) && (count_q < DEPTH_C);
  end

  assign mcu_op  = op_q;
  assign mcu_op0 = op0_q;
  assign mcu_op1 = op1_q;
  assign mcu_op2 = op2_q;

endmodule
